mem_arb_ctrl: RTL and testbench

MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

---
 rtl/mem_arb_ctrl_if.sv | 31 +++
 rtl/mem_arb_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_ctrl_if.sv
// Bus bundle for mem_arb_ctrl: RAM byte port plus the per-channel request
// and completion signals. The slave modport is the arbiter's view; the
// master modport is the requestor/RAM side.
interface mem_arb_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
);
  logic [7:0]                    mem_din;
  logic [7:0]                    mem_dout;
  logic [ADDR_W-1:0]             mem_a;
  logic                          mem_wr;
  logic [NUM_CH-1:0]             ch_req;
  logic [NUM_CH-1:0]             ch_wr;
  logic [NUM_CH-1:0][1:0]        ch_size;
  logic [NUM_CH-1:0]             ch_sext;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][31:0]       ch_wdata;
  logic [NUM_CH-1:0]             ch_valid;
  logic [31:0]                   ch_rdata;
  logic                          busy;

  modport slave (
    input  mem_din, ch_req, ch_wr, ch_size, ch_sext, ch_addr, ch_wdata,
    output mem_dout, mem_a, mem_wr, ch_valid, ch_rdata, busy
  );

  modport master (
    output mem_din, ch_req, ch_wr, ch_size, ch_sext, ch_addr, ch_wdata,
    input  mem_dout, mem_a, mem_wr, ch_valid, ch_rdata, busy
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates NUM_CH requestors onto a byte-wide RAM port and
// splits 1/2/4-byte loads/stores into sequential byte accesses.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration; without it
// the lowest requesting channel index always wins.
module mem_arb_ctrl #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input logic           clk_in,
  input logic           rst_in,
  input logic           rdy_in,
  mem_arb_ctrl_if.slave bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     g_q, g_d;
  logic              wr_q, wr_d, sext_q, sext_d;
  logic [2:0]        n_q, n_d;      // transfer length in bytes: 1, 2 or 4
  logic [2:0]        cnt_q, cnt_d;  // bytes already put on the RAM port
  logic [1:0]        smp_q, smp_d;  // bytes already captured from mem_din
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0][7:0]   wdata_q, wdata_d;
  logic [3:0][7:0]   rdata_q, rdata_d;
  // bit 0: a read address is on mem_a this cycle; bit RD_LAT: its data is on mem_din
  logic [RD_LAT:0]   vld_pipe_q, vld_pipe_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
  logic [CW-1:0]     gnt;
  logic [2:0]        req_n;
  logic              any_req, iss, last_smp;

  assign any_req = |bus.ch_req;

`ifdef MEM_ARB_RR_EN
  logic [CW-1:0] ptr_q, ptr_d, gnt_hi, gnt_lo;
  logic          hit_hi;

  // Round-robin pick: lowest requester above the pointer, else lowest overall
  always_comb begin
    gnt_hi = '0;
    gnt_lo = '0;
    hit_hi = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_req[i]) begin
        if (CW'(i) > ptr_q) begin
          gnt_hi = CW'(i);
          hit_hi = 1'b1;
        end else begin
          gnt_lo = CW'(i);
        end
      end
    end
    gnt = hit_hi ? gnt_hi : gnt_lo;
  end

  assign ptr_d = (state_q == IDLE && any_req) ? gnt : ptr_q;

  // Pointer remembers the last granted channel; reset points at the top so ch0 goes first
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     ptr_q <= CW'(NUM_CH - 1);
    else if (rdy_in) ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest requesting index wins
  always_comb begin
    gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (bus.ch_req[i]) gnt = CW'(i);
  end
`endif

  // Byte count of the channel being granted
  always_comb begin
    case (bus.ch_size[gnt])
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
  end

  // Next-state and registered-output logic; mem outputs fall to zero unless driven
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    wr_d       = wr_q;
    sext_d     = sext_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    smp_d      = smp_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_a_d    = '0;
    mem_wr_d   = 1'b0;
    mem_dout_d = '0;
    ch_valid_d = '0;
    iss        = 1'b0;
    last_smp   = vld_pipe_q[RD_LAT] && ({1'b0, smp_q} == n_q - 3'd1);

    // Read data arrives in address order, so a running byte index is enough
    if (vld_pipe_q[RD_LAT]) begin
      rdata_d[smp_q] = bus.mem_din;
      smp_d          = smp_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (any_req) begin
          g_d        = gnt;
          wr_d       = bus.ch_wr[gnt];
          sext_d     = bus.ch_sext[gnt];
          n_d        = req_n;
          addr_d     = bus.ch_addr[gnt];
          wdata_d    = bus.ch_wdata[gnt];
          cnt_d      = 3'd1;
          smp_d      = '0;
          mem_a_d    = bus.ch_addr[gnt];
          mem_wr_d   = bus.ch_wr[gnt];
          mem_dout_d = bus.ch_wr[gnt] ? bus.ch_wdata[gnt][7:0] : 8'h00;
          iss        = ~bus.ch_wr[gnt];
          state_d    = bus.ch_wr[gnt] ? WRITE : READ;
        end
      end
      READ: begin
        if (cnt_q != n_q) begin
          mem_a_d = addr_q + ADDR_W'(cnt_q);
          cnt_d   = cnt_q + 3'd1;
          iss     = 1'b1;
        end
        if (last_smp) begin
          state_d         = DONE;
          ch_valid_d[g_q] = 1'b1;
          // mem_din is the last byte here, so its MSB is the sign bit
          if (n_q == 3'd1)      rdata_d[3:1] = {24{sext_q & bus.mem_din[7]}};
          else if (n_q == 3'd2) rdata_d[3:2] = {16{sext_q & bus.mem_din[7]}};
        end
      end
      WRITE: begin
        if (cnt_q != n_q) begin
          mem_a_d    = addr_q + ADDR_W'(cnt_q);
          mem_wr_d   = 1'b1;
          mem_dout_d = wdata_q[cnt_q[1:0]];
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d         = DONE;
          ch_valid_d[g_q] = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    vld_pipe_d = {vld_pipe_q[RD_LAT-1:0], iss};
  end

  // State register; rdy_in low freezes everything including the outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      g_q        <= '0;
      wr_q       <= 1'b0;
      sext_q     <= 1'b0;
      n_q        <= '0;
      cnt_q      <= '0;
      smp_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      vld_pipe_q <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      ch_valid_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      g_q        <= g_d;
      wr_q       <= wr_d;
      sext_q     <= sext_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      smp_q      <= smp_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      vld_pipe_q <= vld_pipe_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      ch_valid_q <= ch_valid_d;
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.ch_valid = ch_valid_q;
  assign bus.ch_rdata = rdata_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Scoreboard bench for mem_arb_ctrl: stimulus pushes expected writes, read
// addresses and completions into queues; a negedge monitor pops and compares.
// The RAM model honours rdy_in like every other register in the system.
module tb_mem_arb_ctrl;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int RD_LAT = 1;

  typedef struct { int ch; bit rd; logic [31:0] data; int cyc; } vexp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wexp_t;

  logic clk_in, rst_in, rdy_in;
  mem_arb_ctrl_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  mem_arb_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus)
  );

  int checks = 0, failures = 0, cyc = 0;
  vexp_t vq[$];
  wexp_t wq[$];
  wexp_t aq[$];

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM model with RD_LAT-cycle read pipeline and a preload port
  logic [7:0]  ram [0:262143];
  logic [7:0]  rd_pipe [1:RD_LAT];
  logic        pl_en;
  logic [17:0] pl_addr;
  logic [7:0]  pl_data;
  always @(posedge clk_in) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    if (rdy_in) begin
      if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
      rd_pipe[1] <= ram[bus.mem_a[17:0]];
      for (int i = 2; i <= RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign bus.mem_din = rd_pipe[RD_LAT];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out waiting for ch_valid", nm);
  endtask

  // Monitor: every write, scheduled read address and completion is checked
  always @(negedge clk_in) begin : mon
    vexp_t ve;
    wexp_t we;
    logic [NUM_CH-1:0] oh;
    if (aq.size() != 0 && aq[0].cyc == cyc) begin
      we = aq.pop_front();
      chk("rd_addr", bus.mem_a, we.addr);
      chk("rd_mem_wr", 32'(bus.mem_wr), 32'd0);
    end
    if (bus.mem_wr) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h/%h expected=none", bus.mem_a, bus.mem_dout);
      end else begin
        we = wq.pop_front();
        chk("wr_addr", bus.mem_a, we.addr);
        chk("wr_data", 32'(bus.mem_dout), 32'(we.data));
        chk("wr_cyc", cyc, we.cyc);
      end
    end
    if (bus.ch_valid != '0) begin
      if (vq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%b expected=none", bus.ch_valid);
      end else begin
        ve = vq.pop_front();
        oh = '0;
        oh[ve.ch] = 1'b1;
        chk("valid_ch", 32'(bus.ch_valid), 32'(oh));
        chk("valid_cyc", cyc, ve.cyc);
        if (ve.rd) chk("rdata", bus.ch_rdata, ve.data);
      end
    end
  end

  task automatic preload(input logic [17:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk_in);
    #1 pl_en = 1'b0;
  endtask

  // One transfer on one channel; stall_at>0 drops rdy_in for 5 cycles from that cycle
  task automatic xfer(input int ch, input bit wr, input logic [1:0] size, input bit sext,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input int stall_at);
    int n, cg, k;
    bit got;
    vexp_t ve;
    wexp_t we;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    @(negedge clk_in);
    bus.ch_wr[ch]    = wr;
    bus.ch_size[ch]  = size;
    bus.ch_sext[ch]  = sext;
    bus.ch_addr[ch]  = addr;
    bus.ch_wdata[ch] = wdata;
    bus.ch_req[ch]   = 1'b1;
    @(posedge clk_in);
    #1 cg = cyc;
    // the transfer must use the values latched at grant
    bus.ch_wr[ch]    = ~wr;
    bus.ch_size[ch]  = ~size;
    bus.ch_sext[ch]  = ~sext;
    bus.ch_addr[ch]  = ~addr;
    bus.ch_wdata[ch] = ~wdata;
    for (int i = 0; i < n; i++) begin
      we.addr = addr + 32'(i);
      we.data = wdata[8*i +: 8];
      we.cyc  = cg + i;
      if (wr) wq.push_back(we);
      else if (stall_at == 0) aq.push_back(we);
    end
    ve.ch   = ch;
    ve.rd   = !wr;
    ve.data = exp_rd;
    ve.cyc  = wr ? cg + n : cg + n + RD_LAT + ((stall_at != 0) ? 5 : 0);
    vq.push_back(ve);
    k = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk_in);
      k++;
      if (bus.ch_valid != '0) got = 1'b1;
      if (k == stall_at) rdy_in = 1'b0;
      if (stall_at != 0 && k == stall_at + 5) rdy_in = 1'b1;
    end
    if (!got) timeout("xfer");
    bus.ch_req[ch] = 1'b0;
    rdy_in = 1'b1;
  endtask

  initial begin : stim
    int cg, k, nv, c;
    vexp_t ve;
    wexp_t we;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    bus.ch_req = '0;
    bus.ch_wr = '0;
    bus.ch_size = '0;
    bus.ch_sext = '0;
    bus.ch_addr = '0;
    bus.ch_wdata = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    chk("rst_ch_valid", 32'(bus.ch_valid), 32'd0);
    chk("rst_ch_rdata", bus.ch_rdata, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_in = 1'b1;

    preload(18'h00100, 8'h11); preload(18'h00101, 8'h22);
    preload(18'h00102, 8'h33); preload(18'h00103, 8'h44);
    preload(18'h00200, 8'h80);
    preload(18'h00300, 8'h34); preload(18'h00301, 8'h92);
    preload(18'h00400, 8'h01); preload(18'h00401, 8'h02);
    preload(18'h00402, 8'h03); preload(18'h00403, 8'hF4);
    preload(18'h00500, 8'hA1); preload(18'h00501, 8'hB2);
    preload(18'h00502, 8'hC3); preload(18'h00503, 8'hD4);
    preload(18'h00700, 8'h5C); preload(18'h00710, 8'hC5);

    // loads: width, sign extension, size=11 as 4 bytes
    xfer(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h44332211, 0);
    xfer(0, 1'b0, 2'b00, 1'b1, 32'h200, 32'h0, 32'hFFFFFF80, 0);
    xfer(1, 1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 32'h00000080, 0);
    xfer(0, 1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 32'hFFFF9234, 0);
    xfer(1, 1'b0, 2'b01, 1'b0, 32'h300, 32'h0, 32'h00009234, 0);
    xfer(1, 1'b0, 2'b10, 1'b1, 32'h400, 32'h0, 32'hF4030201, 0);
    xfer(1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h44332211, 0);
    // stores, readback and address wrap-around
    xfer(1, 1'b1, 2'b01, 1'b0, 32'h0003FFFE, 32'hAABBCCDD, 32'h0, 0);
    xfer(0, 1'b0, 2'b01, 1'b0, 32'h0003FFFE, 32'h0, 32'h0000CCDD, 0);
    xfer(0, 1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h11223344, 32'h0, 0);
    xfer(1, 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h00002233, 0);
    xfer(0, 1'b1, 2'b00, 1'b0, 32'h00000800, 32'h000000EE, 32'h0, 0);
    // rdy_in stall mid-read
    xfer(1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'hD4C3B2A1, 2);

    // reset in the middle of a 4-byte store: only the first two bytes go out
    @(negedge clk_in);
    bus.ch_wr[0] = 1'b1;
    bus.ch_size[0] = 2'b10;
    bus.ch_addr[0] = 32'h600;
    bus.ch_wdata[0] = 32'h5A6B7C8D;
    bus.ch_req[0] = 1'b1;
    @(posedge clk_in);
    #1 cg = cyc;
    bus.ch_req = '0;
    we.addr = 32'h600; we.data = 8'h8D; we.cyc = cg;     wq.push_back(we);
    we.addr = 32'h601; we.data = 8'h7C; we.cyc = cg + 1; wq.push_back(we);
    repeat (2) @(negedge clk_in);
    #2 rst_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      chk("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("abort_mem_a", bus.mem_a, 32'd0);
      chk("abort_ch_valid", 32'(bus.ch_valid), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
    end
    chk("abort_ch_rdata", bus.ch_rdata, 32'd0);
    #2 rst_in = 1'b1;

    // both channels requesting continuously: four back-to-back 1-byte loads
    @(negedge clk_in);
    bus.ch_wr = '0;
    bus.ch_size = '0;
    bus.ch_sext = 2'b10;
    bus.ch_addr[0] = 32'h700;
    bus.ch_addr[1] = 32'h710;
    bus.ch_req = 2'b11;
    @(posedge clk_in);
    #1 cg = cyc;
    for (int j = 0; j < 4; j++) begin
`ifdef MEM_ARB_RR_EN
      c = j % 2;
`else
      c = 0;
`endif
      ve.ch = c;
      ve.rd = 1'b1;
      ve.data = (c == 1) ? 32'hFFFFFFC5 : 32'h0000005C;
      ve.cyc = cg + (RD_LAT + 3) * j + 1 + RD_LAT;
      vq.push_back(ve);
      we.addr = (c == 1) ? 32'h710 : 32'h700;
      we.data = 8'h00;
      we.cyc = cg + (RD_LAT + 3) * j;
      aq.push_back(we);
    end
    k = 0;
    nv = 0;
    while (nv < 4 && k < 60) begin
      @(negedge clk_in);
      k++;
      if (bus.ch_valid != '0) nv++;
    end
    if (nv < 4) timeout("arb_seq");
    bus.ch_req = '0;

    repeat (6) @(negedge clk_in);
    chk("pending_valid", vq.size(), 32'd0);
    chk("pending_write", wq.size(), 32'd0);
    chk("pending_rdaddr", aq.size(), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
